axi4_stream_rr_arbiter: RTL and testbench
=========================================

Name: axi4_stream_rr_arbiter

Overview:
- Two-input, one-output AXI4-Stream arbiter. It shares one downstream stream (for example the broadcaster input feeding the FFT and display paths) between two audio sources.
- Grants are packet-granular round-robin: a granted source owns the output until its TLAST beat is transferred.
- The output is a one-deep registered stage, so no combinational path exists from M_AXIS_TREADY to the S_AXIS_TDATA* path.

Parameters:
- DATA_WIDTH, 32, width of all TDATA buses.

Ports:
- AXIS_ACLK  input  1  clock; all logic is on the rising edge.
- AXIS_ARESETN  input  1  reset; asynchronous, active-low.
- S0_AXIS_TDATA  input  DATA_WIDTH  source 0 data.
- S0_AXIS_TVALID  input  1  source 0 valid.
- S0_AXIS_TLAST  input  1  source 0 end of packet.
- S0_AXIS_TREADY  output  1  source 0 ready.
- S1_AXIS_TDATA  input  DATA_WIDTH  source 1 data.
- S1_AXIS_TVALID  input  1  source 1 valid.
- S1_AXIS_TLAST  input  1  source 1 end of packet.
- S1_AXIS_TREADY  output  1  source 1 ready.
- M_AXIS_TDATA  output  DATA_WIDTH  arbitrated data (registered).
- M_AXIS_TVALID  output  1  arbitrated valid (registered).
- M_AXIS_TLAST  output  1  arbitrated last (registered).
- M_AXIS_TREADY  input  1  downstream ready.
- GRANT  output  2  one-hot current owner; 00 when idle.

Behaviour:
- Reset (AXIS_ARESETN low, asynchronous):
  - State = IDLE, priority pointer PRI = 0.
  - M_AXIS_TVALID = 0, M_AXIS_TDATA = 0, M_AXIS_TLAST = 0.
  - GRANT = 00, S0/S1_AXIS_TREADY = 0.
- States:
  - IDLE, BUSY0, BUSY1.
- IDLE:
  - If only one TVALID is high, go to BUSYn for that source.
  - If both are high, go to BUSY[PRI].
  - If neither is high, stay in IDLE.
  - Arbitration takes one cycle. TREADY stays 0 in IDLE, so no beat is accepted in the decision cycle.
- BUSYn:
  - GRANT[n] = 1.
  - Sn_AXIS_TREADY = (!M_AXIS_TVALID || M_AXIS_TREADY). This is combinational from the output register and M_AXIS_TREADY only.
  - The other source's TREADY = 0.
- Accept and output register:
  - Accept = Sn_TVALID && Sn_TREADY.
  - On accept, the output register loads TDATA/TLAST and M_AXIS_TVALID = 1. The beat appears on M one cycle after the accept edge (latency 1).
  - If M_AXIS_TREADY is high, M_AXIS_TVALID is high and there is no new accept, M_AXIS_TVALID clears.
  - While M_AXIS_TVALID is high and M_AXIS_TREADY is low, M_AXIS_TDATA and M_AXIS_TLAST are held stable.
- Full throughput: 1 beat/cycle within a packet while M_AXIS_TREADY is held high.
- Packet end:
  - An accepted beat with TLAST = 1 moves the state to IDLE on the same edge.
  - On that edge, PRI is set to the other source (1 - n).
  - The output register still drains that last beat normally.
  - Minimum inter-packet gap on M is 1 idle-decision cycle.
- Mid-packet TVALID drop:
  - The lock is held and the state stays BUSYn indefinitely.
  - There is no timeout and no preemption.
- Simultaneous TLAST accept and other-source request:
  - The state goes to IDLE, then grants the other source next cycle, because PRI has already flipped.
- A single-beat packet (TLAST on the first beat) is legal and follows the same rules.
- Reset mid-packet:
  - Any buffered beat and the partial packet are dropped. No TLAST is emitted for it.
  - Sources are responsible for restarting.
- GRANT is registered and reflects the state: 00 in IDLE, 01 in BUSY0, 10 in BUSY1.

Decomposition:
- Package axis_arb_pkg:
  - State encoding localparams: IDLE = 2'd0, BUSY0 = 2'd1, BUSY1 = 2'd2.
  - GRANT one-hot constants.
- One natural sub-module: axis_out_reg. This is the one-deep registered output slice (data/last/valid with ready-hold), instantiated once. The arbiter FSM and muxing stay in the top module.

Test Plan:
1. Reset, then S0 sends 4-beat packet 0x10..0x13 with TLAST on 0x13, M_AXIS_TREADY = 1.
   - Required: GRANT = 01 one cycle after TVALID rises.
   - Required: M shows 0x10..0x13 on consecutive cycles, TLAST only with 0x13.
   - Required: GRANT = 00 afterwards.
2. S0 and S1 both valid from reset, each sending 2-beat packets (S0: 0xA0, 0xA1; S1: 0xB0, 0xB1), repeated 3 times.
   - Required: M order is A-pkt, B-pkt, A, B, A, B.
   - Required: there is never interleaving inside a packet.
3. Backpressure: M_AXIS_TREADY low for 5 cycles mid-packet.
   - Required: M_AXIS_TDATA/M_AXIS_TLAST stay constant and M_AXIS_TVALID stays 1.
   - Required: S0_AXIS_TREADY = 0 while M_AXIS_TVALID = 1 and M_AXIS_TREADY = 0.
   - Required: no beat is lost or duplicated (checked by a scoreboard).
4. S1 drops TVALID for 10 cycles mid-packet while S0 is valid.
   - Required: GRANT stays 10 and S0_AXIS_TREADY stays 0.
   - Required: S1's packet completes before S0 is granted.
5. Single-beat packets: S0 sends 0x55 with TLAST = 1 while S1 is waiting.
   - Required: GRANT sequence is 01, 00, 10.
   - Required: 0x55 is output with TLAST = 1.
6. Assert AXIS_ARESETN low asynchronously, mid-cycle, during beat 2 of a 4-beat packet.
   - Required: M_AXIS_TVALID, GRANT and both TREADY signals go 0 immediately, without waiting for a clock edge.
   - Required: after release with both sources valid, the first grant goes to S0 (PRI = 0).

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared definitions for the two-source packet round-robin AXI4-Stream arbiter:
// state encodings and one-hot grant constants.
package axis_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY0 = 2'd1;
  localparam logic [1:0] BUSY1 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_BUSY0 = BUSY0,
    ST_BUSY1 = BUSY1
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_S0   = 2'b01;
  localparam logic [1:0] GRANT_S1   = 2'b10;

endpackage

// File: rtl/axis_out_reg.sv
// One-deep registered AXI4-Stream output slice. It holds data/last stable under
// backpressure and frees itself when the held beat drains.
module axis_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  out_ready,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  logic                  valid_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  last_r;

  // A new beat may enter when the slot is empty or is draining this cycle.
  assign in_ready  = !valid_r || out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_last  = last_r;

  // Output slot: load on accept, clear on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= {DATA_WIDTH{1'b0}};
      last_r  <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= in_data;
      last_r  <= in_last;
    end else if (valid_r && out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/axi4_stream_rr_arbiter.sv
// Two-input AXI4-Stream arbiter with packet-granular round-robin and a registered
// output stage; a grant is held until the owner's TLAST beat is accepted.
module axi4_stream_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  AXIS_ACLK,
  input  logic                  AXIS_ARESETN,
  input  logic [DATA_WIDTH-1:0] S0_AXIS_TDATA,
  input  logic                  S0_AXIS_TVALID,
  input  logic                  S0_AXIS_TLAST,
  output logic                  S0_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0] S1_AXIS_TDATA,
  input  logic                  S1_AXIS_TVALID,
  input  logic                  S1_AXIS_TLAST,
  output logic                  S1_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic [1:0]            GRANT
);

  arb_state_e            state_r;
  logic                  pri_r;
  logic [1:0]            grant_r;

  logic                  out_ready_s;
  logic                  s0_ready_s;
  logic                  s1_ready_s;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  sel_last_s;

  // Ready and beat mux follow the owner; TREADY depends only on the output slot.
  always_comb begin
    s0_ready_s = 1'b0;
    s1_ready_s = 1'b0;
    accept_s   = 1'b0;
    sel_data_s = {DATA_WIDTH{1'b0}};
    sel_last_s = 1'b0;
    case (state_r)
      ST_BUSY0: begin
        s0_ready_s = out_ready_s;
        accept_s   = S0_AXIS_TVALID && out_ready_s;
        sel_data_s = S0_AXIS_TDATA;
        sel_last_s = S0_AXIS_TLAST;
      end
      ST_BUSY1: begin
        s1_ready_s = out_ready_s;
        accept_s   = S1_AXIS_TVALID && out_ready_s;
        sel_data_s = S1_AXIS_TDATA;
        sel_last_s = S1_AXIS_TLAST;
      end
      default: begin
        s0_ready_s = 1'b0;
        s1_ready_s = 1'b0;
      end
    endcase
  end

  assign S0_AXIS_TREADY = s0_ready_s;
  assign S1_AXIS_TREADY = s1_ready_s;
  assign GRANT          = grant_r;

  // Arbiter FSM: one decision cycle in IDLE, lock until the owner's TLAST accept.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_r <= ST_IDLE;
      pri_r   <= 1'b0;
      grant_r <= GRANT_NONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (S0_AXIS_TVALID && S1_AXIS_TVALID) begin
            state_r <= pri_r ? ST_BUSY1 : ST_BUSY0;
            grant_r <= pri_r ? GRANT_S1 : GRANT_S0;
          end else if (S0_AXIS_TVALID) begin
            state_r <= ST_BUSY0;
            grant_r <= GRANT_S0;
          end else if (S1_AXIS_TVALID) begin
            state_r <= ST_BUSY1;
            grant_r <= GRANT_S1;
          end else begin
            state_r <= ST_IDLE;
            grant_r <= GRANT_NONE;
          end
        end
        ST_BUSY0: begin
          if (accept_s && sel_last_s) begin
            state_r <= ST_IDLE;
            grant_r <= GRANT_NONE;
            pri_r   <= 1'b1;
          end else begin
            state_r <= ST_BUSY0;
            grant_r <= GRANT_S0;
          end
        end
        ST_BUSY1: begin
          if (accept_s && sel_last_s) begin
            state_r <= ST_IDLE;
            grant_r <= GRANT_NONE;
            pri_r   <= 1'b0;
          end else begin
            state_r <= ST_BUSY1;
            grant_r <= GRANT_S1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= GRANT_NONE;
        end
      endcase
    end
  end

  axis_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk       (AXIS_ACLK),
    .rst_n     (AXIS_ARESETN),
    .load      (accept_s),
    .in_data   (sel_data_s),
    .in_last   (sel_last_s),
    .out_ready (M_AXIS_TREADY),
    .in_ready  (out_ready_s),
    .out_valid (M_AXIS_TVALID),
    .out_data  (M_AXIS_TDATA),
    .out_last  (M_AXIS_TLAST)
  );

endmodule

// File: tb/tb_axi4_stream_rr_arbiter.sv
// Directed self-checking bench for axi4_stream_rr_arbiter: reset, single packet,
// round-robin order, backpressure, mid-packet valid drop, single-beat packets, async reset.
module tb_axi4_stream_rr_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] S0_AXIS_TDATA, S1_AXIS_TDATA, M_AXIS_TDATA;
  logic          S0_AXIS_TVALID, S0_AXIS_TLAST, S0_AXIS_TREADY;
  logic          S1_AXIS_TVALID, S1_AXIS_TLAST, S1_AXIS_TREADY;
  logic          M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
  logic [1:0]    GRANT;

  int errors = 0;
  int checks = 0;
  logic [DW:0] cap_q[$];

  axi4_stream_rr_arbiter #(.DATA_WIDTH(DW)) dut (
    .AXIS_ACLK      (clk),
    .AXIS_ARESETN   (rst_n),
    .S0_AXIS_TDATA  (S0_AXIS_TDATA),
    .S0_AXIS_TVALID (S0_AXIS_TVALID),
    .S0_AXIS_TLAST  (S0_AXIS_TLAST),
    .S0_AXIS_TREADY (S0_AXIS_TREADY),
    .S1_AXIS_TDATA  (S1_AXIS_TDATA),
    .S1_AXIS_TVALID (S1_AXIS_TVALID),
    .S1_AXIS_TLAST  (S1_AXIS_TLAST),
    .S1_AXIS_TREADY (S1_AXIS_TREADY),
    .M_AXIS_TDATA   (M_AXIS_TDATA),
    .M_AXIS_TVALID  (M_AXIS_TVALID),
    .M_AXIS_TLAST   (M_AXIS_TLAST),
    .M_AXIS_TREADY  (M_AXIS_TREADY),
    .GRANT          (GRANT)
  );

  always #5 clk = ~clk;

  // Scoreboard capture of every beat transferred on M.
  always @(posedge clk) begin
    if (rst_n && M_AXIS_TVALID && M_AXIS_TREADY) cap_q.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int src, input logic [DW-1:0] d, input logic l, input logic v);
    if (src == 0) begin
      S0_AXIS_TDATA = d; S0_AXIS_TLAST = l; S0_AXIS_TVALID = v;
    end else begin
      S1_AXIS_TDATA = d; S1_AXIS_TLAST = l; S1_AXIS_TVALID = v;
    end
  endtask

  task automatic send_beat(input int src, input logic [DW-1:0] d, input logic l);
    logic acc;
    acc = 1'b0;
    drive(src, d, l, 1'b1);
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = (src == 0) ? S0_AXIS_TREADY : S1_AXIS_TREADY;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_beat_timeout: src %0d beat %h never accepted", src, d);
    end
  endtask

  task automatic send_pkt(input int src, input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) send_beat(src, base + DW'(i), (i == n - 1));
    drive(src, {DW{1'b0}}, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, {DW{1'b0}}, 1'b0, 1'b0);
    drive(1, {DW{1'b0}}, 1'b0, 1'b0);
    M_AXIS_TREADY = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    cap_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    M_AXIS_TREADY = 1'b1;
    drive(0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    drive(1, 32'hCAFE_F00D, 1'b1, 1'b1);
    repeat (3) tick();
    checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL reset_mvalid: got %b expected 0", M_AXIS_TVALID); end
    checks++; if (M_AXIS_TDATA !== 32'h0) begin errors++; $display("FAIL reset_mdata: got %h expected 0", M_AXIS_TDATA); end
    checks++; if (M_AXIS_TLAST !== 1'b0) begin errors++; $display("FAIL reset_mlast: got %b expected 0", M_AXIS_TLAST); end
    checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", GRANT); end
    checks++; if ({S1_AXIS_TREADY, S0_AXIS_TREADY} !== 2'b00) begin errors++; $display("FAIL reset_tready: got %b expected 00", {S1_AXIS_TREADY, S0_AXIS_TREADY}); end
    drive(0, {DW{1'b0}}, 1'b0, 1'b0);
    drive(1, {DW{1'b0}}, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    cap_q.delete();
  endtask

  task automatic test_single_packet();
    logic [DW-1:0] exp_d;
    cap_q.delete();
    fork
      send_pkt(0, 32'h10, 4);
      begin
        tick();
        checks++; if (GRANT !== 2'b01) begin errors++; $display("FAIL pkt_grant: got %b expected 01", GRANT); end
        for (int i = 0; i < 4; i++) begin
          tick();
          exp_d = 32'h10 + DW'(i);
          checks++;
          if ({M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA} !== {1'b1, (i == 3), exp_d}) begin
            errors++;
            $display("FAIL pkt_beat%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h", i, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, (i == 3), exp_d);
          end
        end
        checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL pkt_grant_idle: got %b expected 00", GRANT); end
      end
    join
    repeat (2) tick();
  endtask

  task automatic test_round_robin();
    logic [DW:0] exp_q[$];
    do_reset();
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back({1'b0, 32'hA0}); exp_q.push_back({1'b1, 32'hA1});
      exp_q.push_back({1'b0, 32'hB0}); exp_q.push_back({1'b1, 32'hB1});
    end
    fork
      for (int r = 0; r < 3; r++) send_pkt(0, 32'hA0, 2);
      for (int r = 0; r < 3; r++) send_pkt(1, 32'hB0, 2);
    join
    repeat (3) tick();
    checks++; if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL rr_count: got %0d expected %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr_beat%0d: got %h expected %h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    cap_q.delete();
    M_AXIS_TREADY = 1'b1;
    fork
      send_pkt(0, 32'h30, 4);
      begin
        repeat (2) tick();
        M_AXIS_TREADY = 1'b0;
        for (int c = 0; c < 5; c++) begin
          tick();
          checks++;
          if ({M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, S0_AXIS_TREADY} !== {1'b1, 1'b0, 32'h30, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold%0d: got v=%b l=%b d=%h rdy=%b expected v=1 l=0 d=30 rdy=0", c, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, S0_AXIS_TREADY);
          end
        end
        M_AXIS_TREADY = 1'b1;
      end
    join
    repeat (3) tick();
    checks++; if (cap_q.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", cap_q.size()); end
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== {(i == 3), 32'h30 + DW'(i)}) begin
        errors++; $display("FAIL bp_beat%0d: got %h expected %h", i, cap_q[i], {(i == 3), 32'h30 + DW'(i)});
      end
    end
  endtask

  task automatic test_valid_drop();
    logic [DW:0] exp_q[$];
    exp_q = '{{1'b0, 32'hC0}, {1'b0, 32'hC1}, {1'b1, 32'hC2}, {1'b1, 32'hD0}};
    cap_q.delete();
    fork
      begin
        send_beat(1, 32'hC0, 1'b0);
        drive(1, {DW{1'b0}}, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
          tick();
          checks++;
          if ({GRANT, S0_AXIS_TREADY} !== {2'b10, 1'b0}) begin
            errors++; $display("FAIL drop_lock%0d: got grant=%b s0rdy=%b expected grant=10 s0rdy=0", c, GRANT, S0_AXIS_TREADY);
          end
        end
        send_beat(1, 32'hC1, 1'b0);
        send_beat(1, 32'hC2, 1'b1);
        drive(1, {DW{1'b0}}, 1'b0, 1'b0);
      end
      begin
        tick();
        send_pkt(0, 32'hD0, 1);
      end
    join
    repeat (3) tick();
    checks++; if (cap_q.size() != 4) begin errors++; $display("FAIL drop_count: got %0d expected 4", cap_q.size()); end
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL drop_beat%0d: got %h expected %h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_single_beat();
    do_reset();
    fork
      send_pkt(0, 32'h55, 1);
      send_pkt(1, 32'hE0, 1);
      begin
        tick();
        checks++; if (GRANT !== 2'b01) begin errors++; $display("FAIL sb_grant0: got %b expected 01", GRANT); end
        tick();
        checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL sb_grant1: got %b expected 00", GRANT); end
        checks++;
        if ({M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA} !== {1'b1, 1'b1, 32'h55}) begin
          errors++; $display("FAIL sb_beat: got v=%b l=%b d=%h expected v=1 l=1 d=55", M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA);
        end
        tick();
        checks++; if (GRANT !== 2'b10) begin errors++; $display("FAIL sb_grant2: got %b expected 10", GRANT); end
      end
    join
    repeat (3) tick();
    checks++; if (cap_q.size() != 2) begin errors++; $display("FAIL sb_count: got %0d expected 2", cap_q.size()); end
    else if (cap_q[1] !== {1'b1, 32'hE0}) begin errors++; $display("FAIL sb_second: got %h expected 1000000e0", cap_q[1]); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(0, 32'h60, 1'b0, 1'b1);
    repeat (2) tick();
    drive(0, 32'h61, 1'b0, 1'b1);
    tick();
    drive(0, 32'h62, 1'b0, 1'b1);
    checks++;
    if ({M_AXIS_TVALID, M_AXIS_TDATA, GRANT} !== {1'b1, 32'h61, 2'b01}) begin
      errors++; $display("FAIL ar_pre: got v=%b d=%h grant=%b expected v=1 d=61 grant=01", M_AXIS_TVALID, M_AXIS_TDATA, GRANT);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({M_AXIS_TVALID, M_AXIS_TLAST, GRANT, S0_AXIS_TREADY, S1_AXIS_TREADY} !== 6'b0) begin
      errors++;
      $display("FAIL ar_immediate: got v=%b l=%b grant=%b rdy=%b%b expected all 0", M_AXIS_TVALID, M_AXIS_TLAST, GRANT, S1_AXIS_TREADY, S0_AXIS_TREADY);
    end
    drive(0, {DW{1'b0}}, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    cap_q.delete();
    fork
      send_pkt(0, 32'h70, 1);
      send_pkt(1, 32'h80, 1);
      begin
        tick();
        checks++; if (GRANT !== 2'b01) begin errors++; $display("FAIL ar_first_grant: got %b expected 01", GRANT); end
      end
    join
    repeat (3) tick();
    checks++; if (cap_q.size() != 2) begin errors++; $display("FAIL ar_count: got %0d expected 2", cap_q.size()); end
    else if ((cap_q[0] !== {1'b1, 32'h70}) || (cap_q[1] !== {1'b1, 32'h80})) begin
      errors++; $display("FAIL ar_order: got %h %h expected 100000070 100000080", cap_q[0], cap_q[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_valid_drop();
    test_single_beat();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
